// File: rtl/spi_frame_decoder_if.sv
// Interface between the SPI slave receive shifter and the frame decoder.
// The master side is the raw SPI/shifter front; the slave side is the decoder.
interface spi_frame_decoder_if #(
  parameter int AW = 4
);
  logic          sck;
  logic          cs;
  logic [7:0]    rx_byte;
  logic          byte_stb;
  logic          pay_we;
  logic [AW-1:0] pay_addr;
  logic [7:0]    pay_data;
  logic [7:0]    cmd_o;
  logic [7:0]    len_o;
  logic          frame_ok;
  logic          frame_err;

  modport master (
    output sck, cs, rx_byte,
    input  byte_stb, pay_we, pay_addr, pay_data, cmd_o, len_o, frame_ok, frame_err
  );

  modport slave (
    input  sck, cs, rx_byte,
    output byte_stb, pay_we, pay_addr, pay_data, cmd_o, len_o, frame_ok, frame_err
  );
endinterface

// File: rtl/spi_frame_decoder.sv
// Resynchronises SPI strobes, detects completed bytes and parses
// sync/cmd/len/payload/checksum frames into one-cycle register strobes.
module spi_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         AW        = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_frame_decoder_if.slave  bus
);

  typedef enum logic [2:0] {HUNT, CMD, LEN, PAY, CHK} state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  // Strobe resync and edge detection
  logic [1:0] r_sck_s, r_cs_s;
  logic       r_sck_d, r_cs_d;
  logic [2:0] r_cnt;
  logic       r_byte_stb;
  logic [7:0] r_byte;
  logic       w_sck, w_cs, w_fall, w_cs_rise, w_wrap;

  assign w_sck     = r_sck_s[1];
  assign w_cs      = r_cs_s[1];
  assign w_fall    = r_sck_d & ~w_sck;
  assign w_cs_rise = ~r_cs_d & w_cs;
  assign w_wrap    = w_fall & ~w_cs & (r_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_s    <= 2'b00;
      r_cs_s     <= 2'b11;
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b1;
      r_cnt      <= 3'd0;
      r_byte_stb <= 1'b0;
      r_byte     <= 8'h00;
    end else begin
      r_sck_s    <= {r_sck_s[0], bus.sck};
      r_cs_s     <= {r_cs_s[0], bus.cs};
      r_sck_d    <= w_sck;
      r_cs_d     <= w_cs;
      // Deselect discards any partial byte
      if (w_cs)        r_cnt <= 3'd0;
      else if (w_fall) r_cnt <= r_cnt + 3'd1;
      r_byte_stb <= w_wrap;
      if (w_wrap) r_byte <= bus.rx_byte;
    end
  end

  // Parser
  state_t        r_state, w_state;
  logic [7:0]    r_sum, w_sum;
  logic [AW-1:0] r_idx, w_idx;
  logic [7:0]    r_cmd, w_cmd, r_len, w_len;
  logic          r_pay_we, w_pay_we;
  logic [AW-1:0] r_pay_addr, w_pay_addr;
  logic [7:0]    r_pay_data, w_pay_data;
  logic [7:0]    r_cmd_o, w_cmd_o, r_len_o, w_len_o;
  logic          r_ok, w_ok, r_err, w_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_sum      <= 8'h00;
      r_idx      <= '0;
      r_cmd      <= 8'h00;
      r_len      <= 8'h00;
      r_pay_we   <= 1'b0;
      r_pay_addr <= '0;
      r_pay_data <= 8'h00;
      r_cmd_o    <= 8'h00;
      r_len_o    <= 8'h00;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_sum      <= w_sum;
      r_idx      <= w_idx;
      r_cmd      <= w_cmd;
      r_len      <= w_len;
      r_pay_we   <= w_pay_we;
      r_pay_addr <= w_pay_addr;
      r_pay_data <= w_pay_data;
      r_cmd_o    <= w_cmd_o;
      r_len_o    <= w_len_o;
      r_ok       <= w_ok;
      r_err      <= w_err;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_sum      = r_sum;
    w_idx      = r_idx;
    w_cmd      = r_cmd;
    w_len      = r_len;
    w_pay_we   = 1'b0;
    w_pay_addr = r_pay_addr;
    w_pay_data = r_pay_data;
    w_cmd_o    = r_cmd_o;
    w_len_o    = r_len_o;
    w_ok       = 1'b0;
    w_err      = 1'b0;
    if (r_byte_stb) begin
      case (r_state)
        HUNT: if (r_byte == SYNC_BYTE) w_state = CMD;
        CMD: begin
          w_cmd   = r_byte;
          w_sum   = r_byte;
          w_state = LEN;
        end
        LEN: begin
          w_len = r_byte;
          w_sum = r_sum + r_byte;
          if (r_byte > MAX_LEN_B) begin
            w_err   = 1'b1;
            w_state = HUNT;
          end else if (r_byte == 8'h00) begin
            w_state = CHK;
          end else begin
            w_idx   = '0;
            w_state = PAY;
          end
        end
        PAY: begin
          w_pay_we   = 1'b1;
          w_pay_addr = r_idx;
          w_pay_data = r_byte;
          w_sum      = r_sum + r_byte;
          w_idx      = r_idx + 1'b1;
          if (8'(r_idx) == r_len - 8'd1) w_state = CHK;
        end
        CHK: begin
          if (r_byte == r_sum) begin
            w_ok    = 1'b1;
            w_cmd_o = r_cmd;
            w_len_o = r_len;
          end else begin
            w_err = 1'b1;
          end
          w_state = HUNT;
        end
        default: w_state = HUNT;
      endcase
    end
    // The byte landing this cycle is resolved first; a frame it completed is not aborted
    if (w_cs_rise && w_state != HUNT) begin
      w_err   = 1'b1;
      w_state = HUNT;
    end
  end

  assign bus.byte_stb  = r_byte_stb;
  assign bus.pay_we    = r_pay_we;
  assign bus.pay_addr  = r_pay_addr;
  assign bus.pay_data  = r_pay_data;
  assign bus.cmd_o     = r_cmd_o;
  assign bus.len_o     = r_len_o;
  assign bus.frame_ok  = r_ok;
  assign bus.frame_err = r_err;

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Scoreboard bench for spi_frame_decoder: expected write/ok/err events are
// queued as bytes are sent and popped as the decoder emits them.
module tb_spi_frame_decoder;

  localparam int HP = 8;  // sck half-period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_frame_decoder_if #(.AW(4)) bus();

  spi_frame_decoder #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {int kind; int a; int d;} ev_t;  // kind 1=write 2=ok 3=err
  ev_t q[$];

  int n_chk = 0, n_pass = 0;
  int n_stb = 0, n_sent = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic take(input int kind, input int a, input int d);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_event", kind, 0);
    end else begin
      e = q.pop_front();
      chk("ev_kind", kind, e.kind);
      if (e.kind != 3 && kind == e.kind) begin
        chk(kind == 1 ? "pay_addr" : "cmd_o", a, e.a);
        chk(kind == 1 ? "pay_data" : "len_o", d, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.byte_stb)  n_stb++;
      if (bus.pay_we)    take(1, int'(bus.pay_addr), int'(bus.pay_data));
      if (bus.frame_ok)  take(2, int'(bus.cmd_o), int'(bus.len_o));
      if (bus.frame_err) take(3, 0, 0);
    end
  end

  task automatic exp_we(input int a, input int d);  q.push_back('{1, a, d}); endtask
  task automatic exp_ok(input int c, input int l);  q.push_back('{2, c, l}); endtask
  task automatic exp_err();                         q.push_back('{3, 0, 0}); endtask

  task automatic sck_pulse();
    repeat (HP) @(negedge clk);
    bus.sck = 1'b1;
    repeat (HP) @(negedge clk);
    bus.sck = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      sck_pulse();
      if (i == 7) bus.rx_byte = b;
    end
    n_sent++;
  endtask

  task automatic sel();
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic desel();
    repeat (HP) @(negedge clk);
    bus.cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    repeat (12) @(negedge clk);
    chk({tag, "_byte_stb_count"}, n_stb, n_sent);
    chk({tag, "_pending_events"}, q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_byte_stb"},  int'(bus.byte_stb), 0);
    chk({tag, "_pay_we"},    int'(bus.pay_we), 0);
    chk({tag, "_pay_addr"},  int'(bus.pay_addr), 0);
    chk({tag, "_pay_data"},  int'(bus.pay_data), 0);
    chk({tag, "_cmd_o"},     int'(bus.cmd_o), 0);
    chk({tag, "_len_o"},     int'(bus.len_o), 0);
    chk({tag, "_frame_ok"},  int'(bus.frame_ok), 0);
    chk({tag, "_frame_err"}, int'(bus.frame_err), 0);
  endtask

  initial begin
    bus.sck = 1'b0;
    bus.cs = 1'b1;
    bus.rx_byte = 8'h00;

    // Reset with sck toggling, then a lone non-sync byte
    for (int i = 0; i < 4; i++) sck_pulse();
    chk_outputs_zero("rst");
    @(negedge clk) rst_n = 1'b1;
    sel(); sbyte(8'h12); desel();
    settle("lone_byte");

    // Good frame
    sel();
    sbyte(8'hA5); sbyte(8'h03); sbyte(8'h02);
    exp_we(0, 8'h10); sbyte(8'h10);
    exp_we(1, 8'h20); sbyte(8'h20);
    exp_ok(8'h03, 8'h02); sbyte(8'h35);
    desel(); settle("good");

    // Bad checksum
    sel();
    sbyte(8'hA5); sbyte(8'h03); sbyte(8'h02);
    exp_we(0, 8'h10); sbyte(8'h10);
    exp_we(1, 8'h20); sbyte(8'h20);
    exp_err(); sbyte(8'h36);
    desel(); settle("badsum");
    chk("badsum_cmd_hold", int'(bus.cmd_o), 8'h03);
    chk("badsum_len_hold", int'(bus.len_o), 8'h02);

    // Oversize length, then a zero-length frame in the same cs window
    sel();
    sbyte(8'hA5); sbyte(8'h01);
    exp_err(); sbyte(8'h11);
    sbyte(8'hA5); sbyte(8'h01); sbyte(8'h00);
    exp_ok(8'h01, 8'h00); sbyte(8'h01);
    desel(); settle("oversize");

    // Abort mid-payload on cs rise
    sel();
    sbyte(8'hA5); sbyte(8'h07); sbyte(8'h04);
    exp_we(0, 8'hAA); sbyte(8'hAA);
    settle("abort_pre");
    exp_err(); desel();
    settle("abort");
    chk("abort_cmd_hold", int'(bus.cmd_o), 8'h01);
    chk("abort_len_hold", int'(bus.len_o), 8'h00);
    sel();
    sbyte(8'hA5); sbyte(8'h07); sbyte(8'h00);
    exp_ok(8'h07, 8'h00); sbyte(8'h07);
    desel(); settle("post_abort");

    // Partial byte discarded, then sync value carried as payload
    sel();
    for (int i = 0; i < 5; i++) sck_pulse();
    desel(); settle("partial");
    sel();
    sbyte(8'hA5); sbyte(8'h02); sbyte(8'h01);
    exp_we(0, 8'hA5); sbyte(8'hA5);
    exp_ok(8'h02, 8'h01); sbyte(8'hA8);
    desel(); settle("sync_as_data");

    // Async reset mid-frame, then a fresh frame
    sel();
    sbyte(8'hA5); sbyte(8'h03);
    settle("midrst_pre");
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    sbyte(8'hA5); sbyte(8'h05); sbyte(8'h00);
    exp_ok(8'h05, 8'h00); sbyte(8'h05);
    desel(); settle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_frame_decoder.md
Name: spi_frame_decoder

Overview:
- Sits directly downstream of the SPI slave receive shifter, in the FPGA system clock domain.
- Resynchronises the SPI strobes and detects each completed byte.
- Parses the STM32 byte stream into framed commands: sync, cmd, len, payload, checksum.
- Publishes the command, length and payload bytes with one-cycle strobes to the register/actuator logic.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload byte count accepted (1..255).
- AW, 4, payload address width; 2**AW must be >= MAX_LEN.

Ports:
- clk  in  1  system clock; must be >= 8x the sck frequency.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock (raw, async).
- cs  in  1  SPI chip select, active low (raw, async).
- rx_byte  in  8  parallel byte from the SPI slave; updates on the 8th sck falling edge, then stable for 7+ sck periods.
- byte_stb  out  1  one-cycle pulse per completed byte (debug/count).
- pay_we  out  1  payload write strobe.
- pay_addr  out  AW  payload byte index, 0-based.
- pay_data  out  8  payload byte.
- cmd_o  out  8  command of last good frame.
- len_o  out  8  length of last good frame.
- frame_ok  out  1  one-cycle pulse when a frame's checksum matches.
- frame_err  out  1  one-cycle pulse on a bad checksum, len > MAX_LEN, or cs abort mid-frame.

Behaviour:
- Reset: all outputs 0; state HUNT; bit count 0; sum 0; sync flops reset to sck=0, cs=1.
- Synchronisation: sck and cs each pass through 2 flops. A falling edge of synced sck while synced cs=0 increments a 3-bit bit count.
- Byte completion: when the count wraps 7->0, a byte is complete. On the next clk, rx_byte is sampled into a holding register and byte_stb pulses; parser latency from sync'd edge to byte_stb is 1 clk.
- Deselect: synced cs=1 forces bit count 0 every cycle. A partial byte is discarded.
- Parser states:
  - HUNT: byte == SYNC_BYTE -> CMD; other bytes are ignored, no error.
  - CMD: store cmd, sum := byte -> LEN.
  - LEN: store len, sum += byte. If len > MAX_LEN: frame_err, -> HUNT. If len == 0 -> CHK. Otherwise idx := 0 -> PAY.
  - PAY: pay_we=1, pay_addr=idx, pay_data=byte in the same cycle as byte_stb+1; sum += byte; idx++. When idx == len-1 -> CHK.
  - CHK: byte == sum[7:0] (mod-256 sum of cmd, len, payload) -> cmd_o/len_o update and frame_ok pulses in the same cycle; else frame_err. Either way -> HUNT.
- Abort: synced cs rising edge while state != HUNT -> frame_err pulse, -> HUNT. cmd_o/len_o are unchanged. Payload bytes already written stay written; the consumer must gate on frame_ok.
- Back-to-back frames in one cs window are legal: after CHK, a following SYNC_BYTE starts a new frame.
- A SYNC_BYTE value inside CMD/LEN/PAY/CHK is data, not a resync.
- Simultaneous byte completion and cs rise: the byte is processed first, then the abort is evaluated. The abort does not fire if that byte completed the frame.
- Outputs are registered; pulses are exactly 1 clk wide.
- Async reset mid-frame returns to the reset state immediately.

Test Plan:
- Reset: hold rst_n=0 with sck toggling -> all outputs 0; release, send 0x12 -> byte_stb once, no pay_we, no frame pulses.
- Good frame A5 03 02 10 20 35 (sum 03+02+10+20=0x35) -> pay_we at addr 0,1 with 0x10, 0x20; frame_ok=1; cmd_o=0x03; len_o=0x02.
- Bad checksum A5 03 02 10 20 36 -> frame_err pulse; cmd_o/len_o keep prior values; no frame_ok.
- Oversize length A5 01 11 (17 > MAX_LEN=16) -> frame_err after the LEN byte; next A5 01 00 01 -> frame_ok, len_o=0.
- Abort: A5 07 04 AA, then cs high -> frame_err on the cs rise; after re-select, A5 07 00 07 -> frame_ok, cmd_o=0x07.
- Partial byte: 5 sck edges, then cs high, then a full frame A5 02 01 A5 A8 -> no spurious byte; payload 0xA5 is written at addr 0 and treated as data, not a resync; frame_ok.
